// File: rtl/noc_phase_sequencer.sv
// Broadcast op sequencer for the NoC: staging load, then NUM_PHASES compute phases per
// network cycle, with stop/cycle-limit termination and an optional drain-until-idle tail.
module noc_phase_sequencer #(
  parameter int NUM_ROUTERS = 16,
  parameter int NUM_PHASES  = 2,
  parameter int OP_W        = 3,
  parameter int CYC_W       = 32,
  parameter int DRAIN_MAX   = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop_req,
  input  logic [CYC_W-1:0]       max_cycles,
  input  logic                   drain_en,
  input  logic [NUM_ROUTERS-1:0] router_done,
  output logic [OP_W-1:0]        op,
  output logic                   staging_load,
  output logic [CYC_W-1:0]       in_cycle,
  output logic                   busy,
  output logic                   finished,
  output logic                   timeout
);

  localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam int DR_W = $clog2(DRAIN_MAX) + 1;
  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(NUM_PHASES - 1);
  localparam logic [PH_W-1:0]  PH_ONE     = PH_W'(1);
  localparam logic [DR_W-1:0]  DRAIN_LAST = DR_W'(DRAIN_MAX - 1);
  localparam logic [DR_W-1:0]  DR_ONE     = DR_W'(1);
  localparam logic [CYC_W-1:0] CYC_ONE    = CYC_W'(1);
  localparam logic [OP_W-1:0]  OP_LOAD    = OP_W'(1);
  localparam logic [OP_W-1:0]  OP_PH0     = OP_W'(2);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PHASE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CYC_W-1:0] in_cycle_q, in_cycle_d;
  logic [CYC_W-1:0] max_q, max_d;
  logic             drain_en_q, drain_en_d;
  logic             drain_mode_q, drain_mode_d;
  logic [DR_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic             stop_q, stop_d;
  logic             timeout_q, timeout_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;
  logic             fin_q, fin_d;

  logic [CYC_W-1:0] in_inc;
  logic             end_cond;
  logic             all_done;

  assign in_inc   = in_cycle_q + CYC_ONE;
  // A stop request arriving in the last phase itself still ends that round.
  assign end_cond = stop_q | stop_req | ((max_q != '0) && (in_inc == max_q));
  assign all_done = &router_done;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    in_cycle_d   = in_cycle_q;
    max_d        = max_q;
    drain_en_d   = drain_en_q;
    drain_mode_d = drain_mode_q;
    drain_cnt_d  = drain_cnt_q;
    stop_d       = stop_q;
    timeout_d    = timeout_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_LOAD;
          phase_d      = '0;
          in_cycle_d   = '0;
          max_d        = max_cycles;
          drain_en_d   = drain_en;
          drain_mode_d = 1'b0;
          drain_cnt_d  = '0;
          stop_d       = 1'b0;
          timeout_d    = 1'b0;
        end
      end
      S_LOAD: begin
        stop_d  = stop_q | stop_req;
        state_d = S_PHASE;
        phase_d = '0;
      end
      S_PHASE: begin
        stop_d = stop_q | stop_req;
        if (phase_q != PH_LAST) begin
          phase_d = phase_q + PH_ONE;
        end else begin
          in_cycle_d = in_inc;
          phase_d    = '0;
          if (!drain_mode_q) begin
            if (!end_cond) begin
              state_d = S_LOAD;
            end else if (!drain_en_q) begin
              state_d = S_DONE;
            end else begin
              drain_mode_d = 1'b1;
              drain_cnt_d  = '0;
              state_d      = S_LOAD;
            end
          end else if (all_done) begin
            state_d   = S_DONE;
            timeout_d = 1'b0;
          end else if (drain_cnt_q == DRAIN_LAST) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end else begin
            drain_cnt_d = drain_cnt_q + DR_ONE;
            state_d     = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Output registers are loaded from the next state so they track the state register.
    op_d   = '0;
    load_d = 1'b0;
    busy_d = 1'b0;
    fin_d  = 1'b0;
    case (state_d)
      S_LOAD: begin
        op_d   = OP_LOAD;
        load_d = 1'b1;
        busy_d = 1'b1;
      end
      S_PHASE: begin
        op_d   = OP_PH0 + OP_W'(phase_d);
        busy_d = 1'b1;
      end
      S_DONE:  fin_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      in_cycle_q   <= '0;
      max_q        <= '0;
      drain_en_q   <= 1'b0;
      drain_mode_q <= 1'b0;
      drain_cnt_q  <= '0;
      stop_q       <= 1'b0;
      timeout_q    <= 1'b0;
      op_q         <= '0;
      load_q       <= 1'b0;
      busy_q       <= 1'b0;
      fin_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      in_cycle_q   <= in_cycle_d;
      max_q        <= max_d;
      drain_en_q   <= drain_en_d;
      drain_mode_q <= drain_mode_d;
      drain_cnt_q  <= drain_cnt_d;
      stop_q       <= stop_d;
      timeout_q    <= timeout_d;
      op_q         <= op_d;
      load_q       <= load_d;
      busy_q       <= busy_d;
      fin_q        <= fin_d;
    end
  end

  assign op           = op_q;
  assign staging_load = load_q;
  assign in_cycle     = in_cycle_q;
  assign busy         = busy_q;
  assign finished     = fin_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_noc_phase_sequencer.sv
// Directed bench for noc_phase_sequencer: op sequences, stop, cycle limit, drain, timeout, reset.
module tb_noc_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop_req;
  logic [31:0] max_cycles;
  logic        drain_en;
  logic [3:0]  router_done;
  logic [2:0]  op;
  logic        staging_load;
  logic [31:0] in_cycle;
  logic        busy;
  logic        finished;
  logic        timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int n_loads  = 0;

  noc_phase_sequencer #(
    .NUM_ROUTERS(4),
    .NUM_PHASES (2),
    .OP_W       (3),
    .CYC_W      (32),
    .DRAIN_MAX  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop_req    (stop_req),
    .max_cycles  (max_cycles),
    .drain_en    (drain_en),
    .router_done (router_done),
    .op          (op),
    .staging_load(staging_load),
    .in_cycle    (in_cycle),
    .busy        (busy),
    .finished    (finished),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Checks the current broadcast op and its companion flags, then advances one clock.
  task automatic exp_op(input int e);
    chk("op", 32'(op), 32'(e));
    chk("staging_load", 32'(staging_load), (e == 1) ? 32'd1 : 32'd0);
    chk("busy", 32'(busy), (e != 0) ? 32'd1 : 32'd0);
    if (staging_load) n_loads++;
    tick();
  endtask

  task automatic rounds(input int n);
    for (int r = 0; r < n; r++) begin
      exp_op(1);
      exp_op(2);
      exp_op(3);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop_req = 1'b0;
    max_cycles = 0; drain_en = 1'b0; router_done = 4'h0;
    tick(); tick();
    chk("rst_op", 32'(op), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_finished", 32'(finished), 0);
    chk("rst_in_cycle", in_cycle, 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_staging_load", 32'(staging_load), 0);
    rst_n = 1'b1;
    tick();

    // Three-round limit without drain.
    max_cycles = 3; drain_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n_loads = 0;
    rounds(3);
    exp_op(0);
    chk("t1_loads", 32'(n_loads), 3);
    chk("t1_in_cycle", in_cycle, 3);
    chk("t1_finished", 32'(finished), 1);
    chk("t1_timeout", 32'(timeout), 0);

    // Stop in IDLE is ignored; stop in PHASE_0 of round 5 finishes that round.
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    stop_req = 1'b1; tick(); stop_req = 1'b0; tick();
    chk("t2_idle_busy", 32'(busy), 0);
    max_cycles = 0; start = 1'b1;
    tick();
    start = 1'b0;
    rounds(4);
    exp_op(1);
    stop_req = 1'b1;
    exp_op(2);
    stop_req = 1'b0;
    exp_op(3);
    exp_op(0);
    chk("t2_in_cycle", in_cycle, 5);
    chk("t2_finished", 32'(finished), 1);

    // Drain with routers going idle in the third drain round.
    max_cycles = 2; drain_en = 1'b1; router_done = 4'h0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_in_cycle_cleared", in_cycle, 0);
    rounds(4);
    exp_op(1);
    exp_op(2);
    router_done = 4'hF;
    exp_op(3);
    exp_op(0);
    chk("t3_in_cycle", in_cycle, 5);
    chk("t3_timeout", 32'(timeout), 0);
    chk("t3_finished", 32'(finished), 1);

    // Drain that never completes: DRAIN_MAX=4 rounds then timeout.
    router_done = 4'h0; max_cycles = 2; drain_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    rounds(6);
    exp_op(0);
    chk("t4_in_cycle", in_cycle, 6);
    chk("t4_timeout", 32'(timeout), 1);
    chk("t4_finished", 32'(finished), 1);
    chk("t4_busy_and_finished", 32'(busy & finished), 0);

    // Restart from DONE with a single-round limit.
    max_cycles = 1; drain_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_in_cycle_cleared", in_cycle, 0);
    chk("t5_timeout_cleared", 32'(timeout), 0);
    chk("t5_finished_cleared", 32'(finished), 0);
    exp_op(1);
    exp_op(2);
    exp_op(3);
    exp_op(0);
    chk("t5_in_cycle", in_cycle, 1);
    chk("t5_timeout", 32'(timeout), 0);
    chk("t5_finished", 32'(finished), 1);

    // Start while busy is ignored; reset in PHASE_1 of round 2 aborts the run.
    max_cycles = 0; start = 1'b1;
    tick();
    start = 1'b0;
    rounds(1);
    exp_op(1);
    start = 1'b1;
    exp_op(2);
    start = 1'b0;
    chk("t6_op_ph1", 32'(op), 3);
    chk("t6_in_cycle_mid", in_cycle, 1);
    rst_n = 1'b0;
    tick();
    chk("t6_op", 32'(op), 0);
    chk("t6_in_cycle", in_cycle, 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_finished", 32'(finished), 0);
    rst_n = 1'b1;
    tick();
    chk("t6_idle_op", 32'(op), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/noc_phase_sequencer.md
Name: noc_phase_sequencer

Overview:
- Synthesizable, parametrised replacement for the testbench-level LoadStaging/Phase0/Phase1 loop that steps every router in the NoC.
- Issues one broadcast op code per cycle to all routers: staging load, then NUM_PHASES compute phases.
- Counts network cycles, applies stop and cycle-limit conditions, and optionally drains the network until every router reports done.
- Sits at the NoC top level beside the staging interconnect and drives its load strobe.

Parameters:
NUM_ROUTERS, 16, number of router done inputs
NUM_PHASES, 2, compute phases per network cycle (1..4)
OP_W, 3, op code width
CYC_W, 32, network cycle counter width
DRAIN_MAX, 1024, maximum drain rounds before timeout (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin run; honoured only in IDLE or DONE
stop_req  input  1  request graceful stop; latched while busy
max_cycles  input  CYC_W  cycle limit, sampled at start; 0 = unlimited
drain_en  input  1  sampled at start; 1 = drain after stop or limit
router_done  input  NUM_ROUTERS  per-router empty/idle flags
op  output  OP_W  broadcast op: 0 NOP, 1 LoadStaging, 2+k Phase k
staging_load  output  1  one-cycle strobe, high exactly when op==LoadStaging
in_cycle  output  CYC_W  completed network cycles
busy  output  1  high in LOAD, PHASE, DRAIN states
finished  output  1  high in DONE
timeout  output  1  drain ended by DRAIN_MAX; valid while finished

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE. op=0, staging_load=0, in_cycle=0, busy=0, finished=0, timeout=0. Stop latch, drain counter and sampled config are cleared. Reset wins over every other input, including mid-run; a run is never resumed.
- Outputs are registered. op reflects the current state.
- IDLE: op=0. start=1 -> LOAD on the next cycle. Capture max_cycles and drain_en, clear in_cycle.
- LOAD: exactly one cycle. op=1, staging_load=1. Next state is PHASE_0.
- PHASE_k: one cycle each. op=2+k. PHASE_k -> PHASE_k+1 until PHASE_{NUM_PHASES-1}.
- End of round, evaluated in the last phase:
  - in_cycle increments by 1 on the transition out of the last phase. It wraps at 2^CYC_W with no flag.
  - end_cond = stop latch set OR (max_cycles != 0 AND in_cycle+1 == max_cycles), computed on the pre-increment value.
  - If the run is not in drain mode:
    - end_cond=0 -> LOAD.
    - end_cond=1 and drain_en=0 -> DONE.
    - end_cond=1 and drain_en=1 -> enter drain mode, drain counter=0, then LOAD.
  - If the run is in drain mode:
    - &router_done=1 in the last phase -> DONE, timeout=0.
    - Otherwise, if drain counter+1 == DRAIN_MAX -> DONE, timeout=1.
    - Otherwise, increment drain counter -> LOAD.
- Drain rounds use the same LOAD/PHASE sequence and also increment in_cycle. max_cycles is ignored once in drain mode.
- stop_req:
  - Sampled every busy cycle into a sticky latch.
  - Asserting it in the last phase counts for that round.
  - It has no effect in IDLE or DONE.
  - The latch clears on start.
- start while busy: ignored, no restart.
- start and stop_req together in IDLE: the run starts, with stop not latched.
- DONE: finished=1, op=0. in_cycle and timeout are held. start=1 -> LOAD; clears in_cycle, timeout, stop latch and drain counter; resamples config.
- max_cycles=1 means the run ends after exactly one round.
- busy is high in every LOAD, PHASE and drain cycle.
- busy and finished are never both high.

Test Plan:
- Reset, then start with max_cycles=3, drain_en=0, NUM_PHASES=2 -> op sequence 1,2,3,1,2,3,1,2,3,0. staging_load is high 3 times, in_cycle=3, finished=1, timeout=0.
- max_cycles=0, start, stop_req pulsed in the second cycle of round 5 -> the round completes, in_cycle=5, finished=1. A stop pulse asserted in IDLE beforehand is ignored.
- max_cycles=2, drain_en=1, router_done=0 for 3 extra rounds then all ones -> in_cycle=5, timeout=0, finished=1.
- DRAIN_MAX=4, drain_en=1, router_done held 0 -> 4 drain rounds, then finished=1, timeout=1, in_cycle=max_cycles+4.
- Assert rst_n=0 mid-PHASE_1 of round 2 -> next cycle op=0, in_cycle=0, busy=0. A start pulse while busy has no effect.
- After DONE, restart with new max_cycles=1 -> in_cycle clears to 0 and then ends at 1, timeout clears, op sequence is 1,2,3,0.
